// File: rtl/tx_enable_sequencer.sv
// Purpose : sequences the per-stage enables of the TX pipeline. It ramps them up one
//           stage at a time (thermometer code from bit 0) and ramps them down in reverse.
//           An abort forces every enable low.
// Latency : every output is registered. An input change is visible after the next
//           i_clock edge. Enable changes are spaced STAGE_DELAY cycles apart.
// Backpressure: none. i_start, i_stop and i_abort are sampled as levels on every edge.
//
// Ports:
//   i_clock, i_reset        clock and asynchronous active-high reset
//   i_start, i_stop, i_abort  level requests; priority is abort, then stop, then start
//   o_enb[N_STAGES-1:0]     stage enables (bit 0 = valid gen ... bit N-1 = pc 20-to-1)
//   o_state[1:0]            IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3
//   o_up_done, o_down_done  one-cycle pulses on entry to RUN / completion of ramp-down
module tx_enable_sequencer #(
  parameter int N_STAGES    = 8,
  parameter int STAGE_DELAY = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_abort,
  output logic [N_STAGES-1:0] o_enb,
  output logic [1:0]          o_state,
  output logic                o_up_done,
  output logic                o_down_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STAGE_DELAY - 1);

  state_t              r_state;
  logic [N_STAGES-1:0] r_enb;
  logic [7:0]          r_cnt;
  logic                r_up_done;
  logic                r_down_done;

  state_t              w_state_nxt;
  logic [N_STAGES-1:0] w_enb_nxt;
  logic [7:0]          w_cnt_nxt;
  logic                w_up_nxt;
  logic                w_down_nxt;
  logic                w_cnt_hit;
  logic [N_STAGES-1:0] w_enb_up;
  logic [N_STAGES-1:0] w_enb_dn;

  // Shifting keeps o_enb a thermometer code by construction.
  // w_enb_up sets the lowest zero bit, and w_enb_dn clears the highest set bit.
  assign w_enb_up  = {r_enb[N_STAGES-2:0], 1'b1};
  assign w_enb_dn  = {1'b0, r_enb[N_STAGES-1:1]};
  assign w_cnt_hit = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_enb       <= '0;
      r_cnt       <= 8'd0;
      r_up_done   <= 1'b0;
      r_down_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_enb       <= w_enb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_up_done   <= w_up_nxt;
      r_down_done <= w_down_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enb_nxt   = r_enb;
    w_cnt_nxt   = r_cnt;
    w_up_nxt    = 1'b0;
    w_down_nxt  = 1'b0;

    if (i_abort) begin
      w_state_nxt = IDLE;
      w_enb_nxt   = '0;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = 8'd0;
          if (i_start && !i_stop) begin
            w_state_nxt = RAMP_UP;
            w_enb_nxt   = {{(N_STAGES-1){1'b0}}, 1'b1};
          end
        end
        RAMP_UP: begin
          if (i_stop) begin
            // Turn around right away from the current level.
            // If only stage 0 is on, the ramp-down is already complete.
            w_enb_nxt = w_enb_dn;
            w_cnt_nxt = 8'd0;
            if (w_enb_dn == '0) begin
              w_state_nxt = IDLE;
              w_down_nxt  = 1'b1;
            end else begin
              w_state_nxt = RAMP_DOWN;
            end
          end else if (w_cnt_hit) begin
            w_enb_nxt = w_enb_up;
            w_cnt_nxt = 8'd0;
            if (w_enb_up[N_STAGES-1]) begin
              w_state_nxt = RUN;
              w_up_nxt    = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        RUN: begin
          w_cnt_nxt = 8'd0;
          if (i_stop) begin
            w_state_nxt = RAMP_DOWN;
            w_enb_nxt   = w_enb_dn;
          end
        end
        RAMP_DOWN: begin
          if (w_cnt_hit) begin
            w_enb_nxt = w_enb_dn;
            w_cnt_nxt = 8'd0;
            if (w_enb_dn == '0) begin
              w_state_nxt = IDLE;
              w_down_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_enb_nxt   = '0;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  assign o_enb       = r_enb;
  assign o_state     = r_state;
  assign o_up_done   = r_up_done;
  assign o_down_done = r_down_done;

endmodule

// File: tb/tb_tx_enable_sequencer.sv
module tb_tx_enable_sequencer;

  localparam int N  = 8;
  localparam int SD = 4;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start, i_stop, i_abort;
  logic [N-1:0] o_enb;
  logic [1:0]   o_state;
  logic         o_up_done, o_down_done;

  logic         s2_start, s2_stop, s2_abort;
  logic [2:0]   s2_enb;
  logic [1:0]   s2_state;
  logic         s2_up_done, s2_down_done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  tx_enable_sequencer #(.N_STAGES(N), .STAGE_DELAY(SD)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_abort(i_abort), .o_enb(o_enb), .o_state(o_state),
    .o_up_done(o_up_done), .o_down_done(o_down_done)
  );

  tx_enable_sequencer #(.N_STAGES(3), .STAGE_DELAY(1)) dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(s2_start), .i_stop(s2_stop),
    .i_abort(s2_abort), .o_enb(s2_enb), .o_state(s2_state),
    .o_up_done(s2_up_done), .o_down_done(s2_down_done)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the enable level is the number of enabled stages, derived from the edge
  // index at which the current ramp began.
  // Ramp-up:   level = 1 + elapsed / SD.
  // Ramp-down: level = start_level - elapsed / SD.
  int m_mode = 0;   // 0 idle, 1 ramp up, 2 run, 3 ramp down
  int m_lvl  = 0;
  int t_up   = 0;
  int t_dn   = 0;
  int l_dn   = 0;
  int e      = 0;
  bit m_up   = 1'b0;
  bit m_dn   = 1'b0;

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      m_mode = 0; m_lvl = 0; m_up = 1'b0; m_dn = 1'b0;
    end else begin
      e++;
      m_up = 1'b0;
      m_dn = 1'b0;
      if (i_abort) begin
        m_mode = 0; m_lvl = 0;
      end else begin
        case (m_mode)
          0: if (i_start && !i_stop) begin m_mode = 1; t_up = e; m_lvl = 1; end
          1: begin
            if (i_stop) begin
              m_lvl = m_lvl - 1;
              if (m_lvl == 0) begin m_mode = 0; m_dn = 1'b1; end
              else begin m_mode = 3; t_dn = e; l_dn = m_lvl; end
            end else begin
              m_lvl = 1 + (e - t_up) / SD;
              if (m_lvl >= N) begin m_lvl = N; m_mode = 2; m_up = 1'b1; end
            end
          end
          2: if (i_stop) begin m_mode = 3; t_dn = e; l_dn = N - 1; m_lvl = N - 1; end
          default: begin
            m_lvl = l_dn - (e - t_dn) / SD;
            if (m_lvl <= 0) begin m_lvl = 0; m_mode = 0; m_dn = 1'b1; end
          end
        endcase
      end
    end
  end

  always @(negedge i_clock) begin
    if (chk_en) begin
      logic [N-1:0] exp_enb;
      exp_enb = N'((32'd1 << m_lvl) - 32'd1);
      chk("cycle", {20'd0, o_enb, o_state, o_up_done, o_down_done},
          {20'd0, exp_enb, 2'(m_mode), m_up, m_dn});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  task automatic start_pulse();
    i_start = 1'b1; tick(1); i_start = 1'b0;
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1; tick(1); i_stop = 1'b0;
  endtask

  task automatic abort_pulse();
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
  endtask

  initial begin
    i_start = 0; i_stop = 0; i_abort = 0; i_reset = 0;
    s2_start = 0; s2_stop = 0; s2_abort = 0;
    #2 i_reset = 1'b1;
    #1;
    chk("rst_enb", {24'd0, o_enb}, 32'h00);
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_done", {30'd0, o_up_done, o_down_done}, 32'd0);
    #19 i_reset = 1'b0;
    chk_en = 1'b1;
    tick(1);

    // Full ramp-up.
    start_pulse();
    chk("up_e0", {24'd0, o_enb}, 32'h01);
    chk("up_e0_state", {30'd0, o_state}, 32'd1);
    tick(4);  chk("up_e4", {24'd0, o_enb}, 32'h03);
    tick(4);  chk("up_e8", {24'd0, o_enb}, 32'h07);
    tick(20); chk("up_e28", {24'd0, o_enb}, 32'hFF);
    chk("up_done_pulse", {31'd0, o_up_done}, 32'd1);
    chk("run_state", {30'd0, o_state}, 32'd2);
    tick(1);  chk("up_done_clear", {31'd0, o_up_done}, 32'd0);
    tick(3);

    // Full ramp-down.
    stop_pulse();
    chk("dn_e0", {24'd0, o_enb}, 32'h7F);
    tick(4);  chk("dn_e4", {24'd0, o_enb}, 32'h3F);
    tick(23); chk("dn_e27", {24'd0, o_enb}, 32'h01);
    tick(1);  chk("dn_e28", {24'd0, o_enb}, 32'h00);
    chk("down_done_pulse", {31'd0, o_down_done}, 32'd1);
    chk("dn_idle", {30'd0, o_state}, 32'd0);
    tick(2);

    // Stop during ramp-up at level 3.
    start_pulse();
    tick(8);  chk("mid_up", {24'd0, o_enb}, 32'h07);
    stop_pulse();
    chk("mid_turn", {24'd0, o_enb}, 32'h03);
    tick(4);  chk("mid_dn1", {24'd0, o_enb}, 32'h01);
    tick(4);  chk("mid_dn0", {24'd0, o_enb}, 32'h00);
    tick(2);

    // Start and stop together in IDLE.
    i_start = 1'b1; i_stop = 1'b1;
    tick(3);
    chk("startstop_enb", {24'd0, o_enb}, 32'h00);
    chk("startstop_state", {30'd0, o_state}, 32'd0);
    i_start = 1'b0; i_stop = 1'b0;
    tick(1);

    // Start pulses during ramp-down are ignored.
    start_pulse();
    tick(28);
    stop_pulse();
    tick(2);
    repeat (4) begin start_pulse(); tick(2); end
    tick(15);
    chk("ign_start_enb", {24'd0, o_enb}, 32'h00);
    chk("ign_start_state", {30'd0, o_state}, 32'd0);
    tick(2);

    // Abort in RAMP_UP, RUN and RAMP_DOWN, and together with start in IDLE.
    start_pulse(); tick(5); abort_pulse();
    chk("abort_up", {22'd0, o_enb, o_state}, 32'd0);
    start_pulse(); tick(30); abort_pulse();
    chk("abort_run", {22'd0, o_enb, o_state}, 32'd0);
    start_pulse(); tick(28); stop_pulse(); tick(6); abort_pulse();
    chk("abort_dn", {22'd0, o_enb, o_state}, 32'd0);
    i_start = 1'b1; abort_pulse(); i_start = 1'b0;
    chk("abort_start", {22'd0, o_enb, o_state}, 32'd0);
    tick(2);

    // Asynchronous reset mid-ramp, then the first start is honoured on the first edge.
    start_pulse();
    tick(16); chk("pre_rst", {24'd0, o_enb}, 32'h1F);
    #2 i_reset = 1'b1;
    #1;
    chk("async_rst_enb", {24'd0, o_enb}, 32'h00);
    chk("async_rst_state", {30'd0, o_state}, 32'd0);
    tick(1);
    #1 i_reset = 1'b0;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    chk("post_rst_start", {24'd0, o_enb}, 32'h01);
    abort_pulse();
    tick(1);

    // STAGE_DELAY = 1 with N_STAGES = 3: changes on consecutive edges.
    s2_start = 1'b1; tick(1); s2_start = 1'b0;
    chk("sd1_up0", {29'd0, s2_enb}, 32'h1);
    tick(1); chk("sd1_up1", {29'd0, s2_enb}, 32'h3);
    tick(1); chk("sd1_up2", {29'd0, s2_enb}, 32'h7);
    chk("sd1_updone", {29'd0, s2_state, s2_up_done}, {29'd0, 2'd2, 1'b1});
    s2_stop = 1'b1; tick(1); s2_stop = 1'b0;
    chk("sd1_dn0", {29'd0, s2_enb}, 32'h3);
    tick(1); chk("sd1_dn1", {29'd0, s2_enb}, 32'h1);
    tick(1); chk("sd1_dn2", {29'd0, s2_enb}, 32'h0);
    chk("sd1_dndone", {29'd0, s2_state, s2_down_done}, {29'd0, 2'd0, 1'b1});
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
